// File: rtl/osr_pkg.sv
// Shared constants, types and count decode for the PIO shift registers (OSR/ISR).
package osr_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 6;
  localparam int unsigned BITS_W          = 5;
  localparam int unsigned OSR_EMPTY_COUNT = 32;

  // Shift direction encoding as carried by the shift_dir control bit
  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  // Result of one OUT extract: bits handed out and what stays in the register
  typedef struct packed {
    logic [DATA_W-1:0] bits;
    logic [DATA_W-1:0] rem;
  } shift_res_t;

  // 5-bit count field where 0 encodes a full 32-bit word
  function automatic logic [CNT_W-1:0] decode_count(input logic [BITS_W-1:0] v);
    decode_count = (v == '0) ? CNT_W'(OSR_EMPTY_COUNT) : {1'b0, v};
  endfunction

endpackage

// File: rtl/osr_if.sv
// TX FIFO read port as seen between the FIFO (master) and the OSR (slave).
interface osr_if;
  import osr_pkg::*;

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_pull;

  modport master (
    output fifo_empty,
    output fifo_data,
    input  fifo_pull
  );

  modport slave (
    input  fifo_empty,
    input  fifo_data,
    output fifo_pull
  );

endinterface

// File: rtl/osr.sv
// PIO output shift register: MOV/PULL loads, OUT extraction, autopull refill.
module osr
  import osr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              penable,
  input  logic              stalled,
  input  logic              shift_dir,
  input  logic              auto_pull,
  input  logic [BITS_W-1:0] pull_thresh,
  input  logic              do_shift,
  input  logic [BITS_W-1:0] bit_count,
  input  logic              do_pull,
  input  logic              pull_block,
  input  logic              do_set,
  input  logic [DATA_W-1:0] din,
  osr_if.slave              fifo,
  output logic [DATA_W-1:0] dout,
  output logic              osr_stall,
  output logic [CNT_W-1:0]  shift_count,
  output logic [DATA_W-1:0] osr_value
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [DATA_W-1:0] osr_q, osr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_pull_c;

  logic [CNT_W-1:0]  n_bits;
  logic [CNT_W-1:0]  thresh;
  logic [SUM_W-1:0]  count_sum;
  logic              refill_due;
  logic              can_act;
  shift_res_t        sh;

  // Split the register into the n bits handed out and the remainder kept
  function automatic shift_res_t shift_extract(
    input logic [DATA_W-1:0] v,
    input logic [CNT_W-1:0]  n,
    input shift_dir_e        dir
  );
    shift_res_t        r;
    logic [2*DATA_W-1:0] wide;
    logic [2*DATA_W-1:0] mask;
    wide = '0;
    mask = '0;
    if (dir == SHIFT_RIGHT) begin
      mask   = (64'(1) << n) - 64'd1;
      r.bits = v & mask[DATA_W-1:0];
      r.rem  = v >> n;
    end else begin
      wide   = {32'h0, v} << n;
      r.bits = wide[2*DATA_W-1:DATA_W];
      r.rem  = wide[DATA_W-1:0];
    end
    return r;
  endfunction

  // Next-state, OUT data, stall and FIFO pop decision
  always_comb begin
    osr_d       = osr_q;
    count_d     = count_q;
    fifo_pull_c = 1'b0;
    dout        = '0;
    osr_stall   = 1'b0;

    n_bits     = decode_count(bit_count);
    thresh     = decode_count(pull_thresh);
    sh         = shift_extract(osr_q, n_bits, shift_dir_e'(shift_dir));
    count_sum  = SUM_W'(count_q) + SUM_W'(n_bits);
    refill_due = auto_pull && (count_q >= thresh);
    // osr_stall must not depend on stalled, so gating lives only here
    can_act    = penable && !stalled && !reset;

    if (do_set) begin
      if (can_act) begin
        osr_d   = din;
        count_d = '0;
      end
    end else if (do_pull) begin
      if (!fifo.fifo_empty) begin
        if (can_act) begin
          osr_d       = fifo.fifo_data;
          count_d     = '0;
          fifo_pull_c = 1'b1;
        end
      end else if (pull_block) begin
        osr_stall = 1'b1;
      end else if (can_act) begin
        osr_d   = din;
        count_d = '0;
      end
    end else if (do_shift) begin
      if (refill_due) begin
        // OUT waits for a fresh word; it re-executes after the refill
        osr_stall = 1'b1;
        if (!fifo.fifo_empty && can_act) begin
          osr_d       = fifo.fifo_data;
          count_d     = '0;
          fifo_pull_c = 1'b1;
        end
      end else if (can_act) begin
        dout    = sh.bits;
        osr_d   = sh.rem;
        count_d = (count_sum > SUM_W'(OSR_EMPTY_COUNT)) ? CNT_W'(OSR_EMPTY_COUNT)
                                                        : count_sum[CNT_W-1:0];
      end
    end else if (refill_due && !fifo.fifo_empty && can_act) begin
      osr_d       = fifo.fifo_data;
      count_d     = '0;
      fifo_pull_c = 1'b1;
    end
  end

  // Register and shift count, cleared to empty on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      osr_q   <= '0;
      count_q <= CNT_W'(OSR_EMPTY_COUNT);
    end else begin
      osr_q   <= osr_d;
      count_q <= count_d;
    end
  end

  assign fifo.fifo_pull = fifo_pull_c;
  assign shift_count    = count_q;
  assign osr_value      = osr_q;

endmodule
